// File: rtl/mcntrl_pkg.sv
// Shared definitions for the memory-controller channel pagers: page geometry,
// burst limits and the pager state encoding.
package mcntrl_pkg;

  localparam int NUM_PAGES = 4;
  localparam int MAX_BURST = 128;
  localparam int PAGE_W    = $clog2(NUM_PAGES);
  localparam int CNT_W     = $clog2(NUM_PAGES + 1);
  localparam int BURST_W   = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_GRANT = 2'd1,
    ST_PRE        = 2'd2,
    ST_READ       = 2'd3
  } pager_state_e;

  // A programmed length of zero encodes a full page.
  function automatic logic [BURST_W-1:0] burst_words(input logic [7:0] len);
    return (len == 8'd0) ? BURST_W'(MAX_BURST) : BURST_W'(len);
  endfunction

endpackage

// File: rtl/mcntrl_page_cnt.sv
// Saturating up/down page-occupancy counter with a sticky overflow flag;
// shared by the write- and read-channel pagers.
module mcntrl_page_cnt
  import mcntrl_pkg::*;
#(
  parameter int DEPTH = NUM_PAGES,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          overflow_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i && !dec_i) begin
      // A fill arriving with every page occupied is lost; remember it.
      if (cnt_q == CW'(DEPTH)) ovf_d = 1'b1;
      else                     cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // clr_i carries the synchronous reset as well as the channel flush.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
    ovf_q <= ovf_d;
  end

  assign count_o    = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/mcntrl_wbuf_pager.sv
// Write-channel buffer page scheduler: requests the arbiter for each filled
// page, resets the buffer read address, then streams one page out with rd.
module mcntrl_wbuf_pager
  import mcntrl_pkg::*;
#(
  parameter int START_DLY = 2
) (
  input  logic             mclk,
  input  logic             mrst,
  input  logic             chn_en,
  input  logic             page_written,
  input  logic [7:0]       burst_len,
  output logic             want,
  input  logic             grant,
  output logic [PAGE_W-1:0] rpage,
  output logic             raddr_reset,
  output logic             rd,
  output logic             busy,
  output logic [CNT_W-1:0] pages_full,
  output logic             page_released,
  output logic             overflow
);

  pager_state_e        state_q, state_d;
  logic [3:0]          dly_q, dly_d;
  logic [BURST_W-1:0]  words_q, words_d;
  logic [PAGE_W-1:0]   rpage_q, rpage_d;
  logic                rel_q, rel_d;
  logic                flush;
  logic                pages_pending;

  assign flush = mrst || !chn_en;

  mcntrl_page_cnt #(
    .DEPTH (NUM_PAGES),
    .CW    (CNT_W)
  ) u_page_cnt (
    .clk        (mclk),
    .clr_i      (flush),
    .inc_i      (page_written),
    .dec_i      (rel_q),
    .count_o    (pages_full),
    .overflow_o (overflow)
  );

  // The counter only drops at the end of the release cycle, so look ahead
  // there to avoid requesting an empty buffer or adding an extra idle cycle.
  assign pages_pending = rel_q ? ((pages_full > CNT_W'(1)) || page_written)
                               : (pages_full != '0);

  // NOTE: every variable gets a default at the top of a combinational block so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    words_d = words_q;
    rpage_d = rpage_q;
    rel_d   = 1'b0;
    if (rel_q) rpage_d = rpage_q + PAGE_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (pages_pending) state_d = ST_WAIT_GRANT;
      end
      ST_WAIT_GRANT: begin
        if (grant) begin
          state_d = ST_PRE;
          dly_d   = 4'(START_DLY);
          words_d = burst_words(burst_len);
        end
      end
      ST_PRE: begin
        if (dly_q == 4'd0) state_d = ST_READ;
        else               dly_d   = dly_q - 4'd1;
      end
      ST_READ: begin
        words_d = words_q - BURST_W'(1);
        if (words_q == BURST_W'(1)) begin
          state_d = ST_IDLE;
          rel_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disabling the channel abandons the page in flight without releasing it.
    if (!chn_en) begin
      state_d = ST_IDLE;
      dly_d   = '0;
      words_d = '0;
      rpage_d = '0;
      rel_d   = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge mclk) begin
    if (mrst) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      words_q <= '0;
      rpage_q <= '0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      words_q <= words_d;
      rpage_q <= rpage_d;
      rel_q   <= rel_d;
    end
  end

  // raddr_reset only on the first PRE cycle, so it can never overlap rd.
  always_comb begin
    want          = (state_q == ST_WAIT_GRANT);
    raddr_reset   = (state_q == ST_PRE) && (dly_q == 4'(START_DLY));
    rd            = (state_q == ST_READ);
    busy          = (state_q != ST_IDLE);
    page_released = rel_q;
    rpage         = rpage_q;
  end

endmodule
